// File: rtl/shifter_seq_pkg.sv
// Shared types and sizing helpers for the multi-cycle shifter/rotator.
// Imported by shifter_step and shifter_seq.
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shifter_state_e;

  typedef struct packed {
    logic en;
    logic left;
    logic rotate;
    logic arith;
  } shifter_mode_t;

  // Number of SHIFT cycles needed to consume every shift-amount bit of a
  // width-bit operand when bits_per_cycle amount bits are resolved per cycle.
  function automatic int num_steps(int width, int bits_per_cycle);
    return ($clog2(width) + bits_per_cycle - 1) / bits_per_cycle;
  endfunction

endpackage

// File: rtl/shifter_seq_step.sv
// One shift stage: shifts data by a BitsPerCycle-bit group of the amount,
// weighted by the step index. Purely combinational; reused every SHIFT cycle.
module shifter_step
  import shifter_pkg::*;
#(
  parameter int BitWidth     = 32,
  parameter int BitsPerCycle = 1,
  parameter int StepWidth    = 1
) (
  input  logic [BitWidth-1:0]     data_i,
  input  logic [BitsPerCycle-1:0] group_i,
  input  logic [StepWidth-1:0]    step_i,
  input  logic                    left_i,
  input  logic                    rotate_i,
  input  logic                    fill_i,
  output logic [BitWidth-1:0]     data_o
);

  localparam int ShiftWidth = $clog2(BitWidth);
  localparam int AmtWidth   = num_steps(BitWidth, BitsPerCycle) * BitsPerCycle;

  logic [AmtWidth-1:0]   amt_wide;
  logic [ShiftWidth-1:0] amt;
  logic [2*BitWidth-1:0] dbl;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the branches can leave a value held and infer a latch.
    amt_wide = '0;
    amt      = '0;
    dbl      = '0;
    data_o   = '0;

    // Place the group at its binary weight; the bits past ShiftWidth are
    // padding of the last group and are always zero.
    amt_wide = AmtWidth'(group_i) << (step_i * BitsPerCycle);
    amt      = ShiftWidth'(amt_wide);

    if (left_i) begin
      dbl    = {data_i, (rotate_i ? data_i : {BitWidth{1'b0}})} << amt;
      data_o = dbl[2*BitWidth-1 -: BitWidth];
    end else begin
      dbl    = {(rotate_i ? data_i : {BitWidth{fill_i}}), data_i} >> amt;
      data_o = dbl[BitWidth-1:0];
    end
  end

endmodule

// File: rtl/shifter_seq.sv
// Multi-cycle shifter/rotator with valid/ready handshakes on both sides.
// Define SHIFTER_SEQ_ARITH_EN to enable arithmetic (sign-fill) right shifts.
module shifter_seq
  import shifter_pkg::*;
#(
  parameter int BitWidth     = 32,
  parameter int BitsPerCycle = 1
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        InValid,
  output logic                        InReady,
  input  logic                        En,
  input  logic                        Left,
  input  logic                        RotateEnable,
  input  logic                        Arith,
  input  logic [BitWidth-1:0]         dIN,
  input  logic [$clog2(BitWidth)-1:0] ShAmount,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic [BitWidth-1:0]         dOUT
);

  localparam int NumSteps  = num_steps(BitWidth, BitsPerCycle);
  localparam int AmtWidth  = NumSteps * BitsPerCycle;
  localparam int StepWidth = (NumSteps > 1) ? $clog2(NumSteps) : 1;
  localparam int LastStep  = NumSteps - 1;

  shifter_state_e       state_q;
  shifter_mode_t        mode_q;
  logic [BitWidth-1:0]  data_q;
  logic [AmtWidth-1:0]  amt_q;
  logic [StepWidth-1:0] step_q;
  logic                 in_ready_q;
  logic                 out_valid_q;

  logic [BitWidth-1:0]     data_d;
  logic [BitsPerCycle-1:0] group;
  logic                    fill;
  logic                    arith_cap;

  assign group = amt_q[step_q*BitsPerCycle +: BitsPerCycle];

`ifdef SHIFTER_SEQ_ARITH_EN
  // Arithmetic fill keeps the MSB intact, so data_q's MSB is the captured sign.
  assign arith_cap = Arith & ~Left & ~RotateEnable;
  assign fill      = mode_q.arith & data_q[BitWidth-1];
`else
  assign arith_cap = 1'b0;
  assign fill      = 1'b0;
`endif

  shifter_step #(
    .BitWidth    (BitWidth),
    .BitsPerCycle(BitsPerCycle),
    .StepWidth   (StepWidth)
  ) u_step (
    .data_i  (data_q),
    .group_i (group),
    .step_i  (step_q),
    .left_i  (mode_q.left),
    .rotate_i(mode_q.rotate),
    .fill_i  (fill),
    .data_o  (data_d)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      data_q      <= '0;
      amt_q       <= '0;
      step_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (InValid) begin
            mode_q     <= '{en: En, left: Left, rotate: RotateEnable, arith: arith_cap};
            data_q     <= dIN;
            // A disabled request shifts by zero, so it rides the bypass path.
            amt_q      <= En ? AmtWidth'(ShAmount) : '0;
            step_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          data_q <= data_d;
          step_q <= step_q + 1'b1;
          // Bypass spends exactly one identity cycle here before DONE.
          if (step_q == StepWidth'(LastStep) || amt_q == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (OutReady) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = out_valid_q;
  assign dOUT     = data_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Self-checking bench: two 8-bit instances (1 and 3 amount bits per cycle)
// driven in lockstep and compared against a bit-at-a-time reference model.
module tb_shifter_seq;

`ifdef SHIFTER_SEQ_ARITH_EN
  localparam bit ArithOn = 1'b1;
`else
  localparam bit ArithOn = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst;
  logic       InValid, En, Left, RotateEnable, Arith, OutReady;
  logic [7:0] dIN;
  logic [2:0] ShAmount;

  logic       in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [7:0] dout_a, dout_b;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  shifter_seq #(.BitWidth(8), .BitsPerCycle(1)) dut_a (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(in_ready_a),
    .En(En), .Left(Left), .RotateEnable(RotateEnable), .Arith(Arith),
    .dIN(dIN), .ShAmount(ShAmount), .OutValid(out_valid_a),
    .OutReady(OutReady), .dOUT(dout_a)
  );

  shifter_seq #(.BitWidth(8), .BitsPerCycle(3)) dut_b (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(in_ready_b),
    .En(En), .Left(Left), .RotateEnable(RotateEnable), .Arith(Arith),
    .dIN(dIN), .ShAmount(ShAmount), .OutValid(out_valid_b),
    .OutReady(OutReady), .dOUT(dout_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: apply the shift one bit position at a time.
  function automatic logic [7:0] ref_shift(input logic en, input logic left, input logic rot,
                                           input logic arith, input logic [7:0] d, input int amt);
    logic [7:0] r;
    r = d;
    if (!en) return d;
    for (int i = 0; i < amt; i++) begin
      if (left) r = rot ? {r[6:0], r[7]} : {r[6:0], 1'b0};
      else      r = rot ? {r[0], r[7:1]} : {(ArithOn && arith) ? r[7] : 1'b0, r[7:1]};
    end
    return r;
  endfunction

  task automatic run_req(input string tag, input logic en, input logic left, input logic rot,
                         input logic arith, input logic [7:0] d, input logic [2:0] amt,
                         input int hold);
    logic [7:0] exp, got_a, got_b;
    int lat_a, lat_b, exp_lat_a;
    exp       = ref_shift(en, left, rot, arith, d, int'(amt));
    exp_lat_a = (!en || amt == 3'd0) ? 1 : 3;
    got_a     = 'x;
    got_b     = 'x;
    lat_a     = 0;
    lat_b     = 0;

    @(negedge Clk);
    check({tag, "/in_ready_a"}, in_ready_a, 1);
    check({tag, "/in_ready_b"}, in_ready_b, 1);
    InValid = 1'b1; En = en; Left = left; RotateEnable = rot; Arith = arith;
    dIN = d; ShAmount = amt;
    @(posedge Clk);
    #1;
    // Scramble the inputs: the request must only use captured values.
    InValid = 1'b0;
    dIN = 8'($urandom); ShAmount = 3'($urandom);
    En = 1'($urandom); Left = 1'($urandom); RotateEnable = 1'($urandom); Arith = 1'($urandom);

    for (int n = 1; n <= 20 && (lat_a == 0 || lat_b == 0); n++) begin
      @(posedge Clk);
      #1;
      if (out_valid_a && lat_a == 0) begin lat_a = n; got_a = dout_a; end
      if (out_valid_b && lat_b == 0) begin lat_b = n; got_b = dout_b; end
    end
    check({tag, "/lat_a"}, lat_a, exp_lat_a);
    check({tag, "/lat_b"}, lat_b, 1);
    check({tag, "/dout_a"}, got_a, exp);
    check({tag, "/dout_b"}, got_b, exp);

    for (int i = 0; i < hold; i++) begin
      @(posedge Clk);
      #1;
      check({tag, "/hold_valid_a"}, out_valid_a, 1);
      check({tag, "/hold_dout_a"}, dout_a, exp);
      check({tag, "/hold_ready_a"}, in_ready_a, 0);
      check({tag, "/hold_valid_b"}, out_valid_b, 1);
      check({tag, "/hold_dout_b"}, dout_b, exp);
    end

    @(negedge Clk);
    OutReady = 1'b1;
    @(posedge Clk);
    #1;
    OutReady = 1'b0;
    check({tag, "/post_valid_a"}, out_valid_a, 0);
    check({tag, "/post_ready_a"}, in_ready_a, 1);
    check({tag, "/post_valid_b"}, out_valid_b, 0);
    check({tag, "/post_ready_b"}, in_ready_b, 1);
  endtask

  initial begin
    Rst = 1'b1; InValid = 1'b0; En = 1'b0; Left = 1'b0; RotateEnable = 1'b0;
    Arith = 1'b0; OutReady = 1'b0; dIN = '0; ShAmount = '0;

    #12;
    check("rst/valid_a", out_valid_a, 0);
    check("rst/dout_a", dout_a, 0);
    check("rst/ready_a", in_ready_a, 1);
    check("rst/valid_b", out_valid_b, 0);
    check("rst/ready_b", in_ready_b, 1);
    @(negedge Clk);
    Rst = 1'b0;

    run_req("rotl2",  1, 1, 1, 0, 8'b0001_0110, 3'd2, 0);
    check("rotl2_ref", ref_shift(1, 1, 1, 0, 8'b0001_0110, 2), 8'b0101_1000);
    run_req("rotr3",  1, 0, 1, 0, 8'h96, 3'd3, 0);
    run_req("lsr2",   1, 0, 0, 0, 8'h96, 3'd2, 0);
    run_req("asr2",   1, 0, 0, 1, 8'h96, 3'd2, 0);
    run_req("asrrot", 1, 0, 1, 1, 8'h96, 3'd3, 0);
    run_req("lsl7",   1, 1, 0, 0, 8'hFF, 3'd7, 0);
    run_req("rotl7",  1, 1, 1, 0, 8'h81, 3'd7, 0);
    run_req("asr7",   1, 0, 0, 1, 8'h80, 3'd7, 0);
    run_req("en0",    0, 1, 0, 0, 8'h5A, 3'd4, 0);
    run_req("amt0",   1, 0, 0, 1, 8'h5A, 3'd0, 0);
    run_req("hold10", 1, 0, 0, 0, 8'hC3, 3'd5, 10);
    run_req("b2b",    1, 1, 0, 0, 8'h3C, 3'd1, 0);

    // Reset in the middle of an operation: dut_a is shifting, dut_b is done.
    @(negedge Clk);
    InValid = 1'b1; En = 1'b1; Left = 1'b0; RotateEnable = 1'b0; Arith = 1'b0;
    dIN = 8'hA5; ShAmount = 3'd5;
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    check("midrst/valid_a", out_valid_a, 0);
    check("midrst/dout_a", dout_a, 0);
    check("midrst/ready_a", in_ready_a, 1);
    check("midrst/valid_b", out_valid_b, 0);
    check("midrst/dout_b", dout_b, 0);
    check("midrst/ready_b", in_ready_b, 1);
    @(negedge Clk);
    Rst = 1'b0;
    run_req("after_rst", 1, 0, 1, 0, 8'h96, 3'd3, 0);

    for (int i = 0; i < 24; i++) begin
      run_req("rand", 1'($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom),
              1'($urandom), 8'($urandom), 3'($urandom), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shifter_seq.md
# shifter_seq

Multi-cycle, parametrised shifter/rotator with valid/ready handshakes on input and output. It is the sequential successor to the team's single-cycle combinational shifter. It adds arithmetic right shift, a configurable number of shift-amount bits resolved per cycle (trading area for latency), and back-pressure on the result. It sits between register-file read and writeback in the execute path, wherever a full-width single-cycle barrel shifter does not meet timing or area.

## Interface
- BitWidth, 32: data width; power of two, ≥ 4.
- BitsPerCycle, 1: shift-amount bits resolved per SHIFT cycle; 1 ≤ BitsPerCycle ≤ ShiftWidth.
- ShiftWidth (localparam): $clog2(BitWidth). NumSteps (localparam): ceil(ShiftWidth / BitsPerCycle).
- Clk  input  1: sole clock, rising edge.
- Rst  input  1: asynchronous, active-high reset.
- InValid  input  1: request present.
- InReady  output  1: request accepted when InValid && InReady at a rising edge.
- En  input  1: if 0, result = dIN unchanged.
- Left  input  1: 1 = shift left, 0 = shift right.
- RotateEnable  input  1: rotate instead of fill.
- Arith  input  1: right shifts fill with dIN[BitWidth-1]; ignored when Left=1 or RotateEnable=1.
- dIN  input  BitWidth: operand.
- ShAmount  input  ShiftWidth: shift distance, 0..BitWidth-1.
- OutValid  output  1: dOUT holds a result.
- OutReady  input  1: result consumed when OutValid && OutReady at a rising edge.
- dOUT  output  BitWidth: result.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state: IDLE.
- IDLE: InReady=1. On accept, capture dIN, the mode bits and ShAmount; clear the step counter.
  - If En=0 or ShAmount=0: the data register takes dIN; go to DONE.
  - Otherwise: go to SHIFT.
- SHIFT: on step s, apply amount bits [s·BitsPerCycle +: BitsPerCycle], LSB group first. Each set bit j shifts by 2^j, all as one combined shift for the group. After step NumSteps-1, go to DONE.
- DONE: OutValid=1 and dOUT = data register. Hold dOUT stable until OutReady; on handshake go to IDLE.
- Fill rules:
  - Logical: zero fill.
  - Arith right: replicate the captured sign bit.
  - Rotate: bits wrap around. Rotate takes precedence over Arith.
- Requests use captured values only; input changes after accept have no effect.
- InReady = (state == IDLE), registered-state decode, with no combinational path from any input. One request in flight.
- Shift by BitWidth-1 is legal. Left shift by BitWidth-1 leaves only dIN[0] at the MSB.

## Timing
- Reset values: OutValid=0, dOUT=0, InReady=1, state=IDLE, step counter=0.
- Accept at edge k with a nonzero shift: OutValid rises after edge k+NumSteps.
- Bypass (En=0 or ShAmount=0): OutValid rises after edge k+1.
- Earliest next accept is the edge after the output handshake. Peak throughput is one result per NumSteps+2 cycles (bypass: 3).
- OutReady low: DONE persists indefinitely; dOUT and OutValid stay stable.
- OutReady may be high before OutValid; it has no effect outside DONE.
- Rst asserted in any state: the operation is aborted immediately, with no output and outputs at reset values. The first accept is possible at the first edge after deassertion.

## Configuration
- SHIFTER_SEQ_ARITH_EN defined: Arith behaves as specified.
- Not defined: the Arith port remains but is ignored (treated as 0); right shifts zero-fill, and no sign-fill logic is synthesised.

## Structure
- Package shifter_pkg:
  - typedef enum logic [1:0] shifter_state_e {IDLE, SHIFT, DONE}.
  - Packed struct shifter_mode_t {En, Left, RotateEnable, Arith}.
  - Function num_steps(int width, int bits_per_cycle).
- Sub-module shifter_step:
  - Combinational; shifts by a BitsPerCycle-bit group at a given weight offset.
  - Mode inputs: direction, rotate, fill bit.
  - Instantiated once and reused each SHIFT cycle.

## Test plan
- BitWidth=8, BitsPerCycle=1, dIN=8'b00010110, Left=1, Rotate=1, ShAmount=2 -> dOUT=8'b01011000; OutValid rises 3 cycles after accept.
- dIN=8'h96, right rotate, ShAmount=3 -> 8'hD2. Right logical, ShAmount=2 -> 8'h25. Right Arith, ShAmount=2 -> 8'hE5 with macro, 8'h25 without.
- dIN=8'hFF, left logical, ShAmount=7 -> 8'h80. Repeat with BitsPerCycle=3 -> same value, OutValid after 1 step.
- En=0 or ShAmount=0, dIN=8'h5A -> dOUT=8'h5A, OutValid one cycle after accept.
- Hold OutReady low 10 cycles in DONE -> dOUT/OutValid stable, InReady=0. Then pulse OutReady -> back to IDLE, next request accepted the following edge.
- Assert Rst mid-SHIFT -> OutValid=0, dOUT=0, InReady=1 immediately. A fresh request after deassertion completes correctly.
